// File: rtl/mem_access_stage.sv
// Load/store stage: issues one req/ack bus access per load or store, stalls the
// core while the access is in flight and returns aligned, extended load data.
module mem_access_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] alu_out,
  input  logic [31:0] rs2_data,
  input  logic [2:0]  fn3,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] load_data,
  output logic        stall,
  output logic        misalign,
  output logic        bus_err
);

  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

  state_t        state_reg;
  logic [CW-1:0] wait_cnt_reg;
  logic [2:0]    fn3_reg;
  logic [1:0]    off_reg;
  logic          mem_req_reg;
  logic          mem_we_reg;
  logic [31:0]   mem_addr_reg;
  logic [31:0]   mem_wdata_reg;
  logic [3:0]    mem_wstrb_reg;
  logic [31:0]   load_data_reg;
  logic          bus_err_reg;

  logic          acc;
  logic          fn3_ok;
  logic          misaligned;
  logic          legal;
  logic [31:0]   mem_wdata_next;
  logic [3:0]    mem_wstrb_next;
  logic [7:0]    rbyte [4];
  logic [15:0]   rhalf [2];
  logic [7:0]    sel_byte;
  logic [15:0]   sel_half;
  logic [31:0]   rdata_fmt;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_byte
      assign rbyte[gi] = mem_rdata[8*gi +: 8];
    end
    for (gi = 0; gi < 2; gi++) begin : g_half
      assign rhalf[gi] = mem_rdata[16*gi +: 16];
    end
  endgenerate

  // Request decode: legality and lane placement of the store data.
  always_comb begin
    acc        = mem_read | mem_write;
    fn3_ok     = 1'b0;
    misaligned = 1'b0;
    case (fn3)
      3'b000, 3'b001, 3'b010: fn3_ok = 1'b1;
      3'b100, 3'b101:         fn3_ok = ~mem_write;
      default:                fn3_ok = 1'b0;
    endcase
    if (fn3[1:0] == 2'b01)
      misaligned = alu_out[0];
    else if (fn3[1:0] == 2'b10)
      misaligned = (alu_out[1:0] != 2'b00);
    legal = fn3_ok & ~misaligned;

    mem_wdata_next = 32'h0;
    mem_wstrb_next = 4'b0000;
    if (mem_write) begin
      case (fn3[1:0])
        2'b00: begin
          mem_wdata_next = {4{rs2_data[7:0]}};
          mem_wstrb_next = 4'b0001 << alu_out[1:0];
        end
        2'b01: begin
          mem_wdata_next = {2{rs2_data[15:0]}};
          mem_wstrb_next = 4'b0011 << alu_out[1:0];
        end
        default: begin
          mem_wdata_next = rs2_data;
          mem_wstrb_next = 4'b1111;
        end
      endcase
    end
  end

  // Read lane selection uses the offset latched at issue, not the live address.
  always_comb begin
    sel_byte = rbyte[off_reg];
    sel_half = rhalf[off_reg[1]];
    case (fn3_reg)
      3'b000:  rdata_fmt = {{24{sel_byte[7]}}, sel_byte};
      3'b001:  rdata_fmt = {{16{sel_half[15]}}, sel_half};
      3'b100:  rdata_fmt = {24'h0, sel_byte};
      3'b101:  rdata_fmt = {16'h0, sel_half};
      default: rdata_fmt = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      wait_cnt_reg  <= '0;
      fn3_reg       <= 3'b000;
      off_reg       <= 2'b00;
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= 32'h0;
      mem_wdata_reg <= 32'h0;
      mem_wstrb_reg <= 4'b0000;
      load_data_reg <= 32'h0;
      bus_err_reg   <= 1'b0;
    end else begin
      bus_err_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (acc && legal) begin
            mem_addr_reg  <= {alu_out[31:2], 2'b00};
            mem_wdata_reg <= mem_wdata_next;
            mem_wstrb_reg <= mem_wstrb_next;
            mem_we_reg    <= mem_write;
            fn3_reg       <= fn3;
            off_reg       <= alu_out[1:0];
            wait_cnt_reg  <= '0;
            mem_req_reg   <= 1'b1;
            state_reg     <= REQ;
          end else if (acc) begin
            load_data_reg <= 32'h0;
          end
        end
        REQ: begin
          if (mem_ack) begin
            mem_req_reg   <= 1'b0;
            load_data_reg <= mem_we_reg ? 32'h0 : rdata_fmt;
            state_reg     <= DONE;
          end else if (wait_cnt_reg == CW'(TIMEOUT - 1)) begin
            mem_req_reg   <= 1'b0;
            load_data_reg <= 32'h0;
            bus_err_reg   <= 1'b1;
            state_reg     <= ERR;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + CW'(1);
          end
        end
        DONE:    state_reg <= IDLE;
        ERR:     state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign stall     = (state_reg == REQ) || ((state_reg == IDLE) && acc && legal);
  assign misalign  = (state_reg == IDLE) && acc && !legal;
  assign mem_req   = mem_req_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign mem_wstrb = mem_wstrb_reg;
  assign load_data = load_data_reg;
  assign bus_err   = bus_err_reg;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed scenarios plus randomized loads/stores
// checked against an arithmetic model of alignment, strobes and extension.
module tb_mem_access_stage;

  localparam int TO = 16;

  logic        clk;
  logic        rst;
  logic [31:0] alu_out;
  logic [31:0] rs2_data;
  logic [2:0]  fn3;
  logic        mem_read;
  logic        mem_write;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] load_data;
  logic        stall;
  logic        misalign;
  logic        bus_err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        stall_idle;
    logic        mis_idle;
    int          req_cycles;
    logic        stall_req;
    logic        stable;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        we;
    logic        stall_end;
    logic        bus_err_end;
    logic [31:0] load_end;
    logic        req_after;
    logic        bus_err_after;
  } obs_t;

  mem_access_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .alu_out(alu_out), .rs2_data(rs2_data), .fn3(fn3),
    .mem_read(mem_read), .mem_write(mem_write), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .load_data(load_data),
    .stall(stall), .misalign(misalign), .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic bit legal_m(bit st, logic [2:0] f, logic [31:0] a);
    int sz;
    if (f == 3'd3 || f == 3'd6 || f == 3'd7) return 1'b0;
    if (st && f[2]) return 1'b0;
    sz = 1 << f[1:0];
    return (int'(a[1:0]) % sz) == 0;
  endfunction

  function automatic logic [31:0] load_m(logic [2:0] f, logic [1:0] off, logic [31:0] rd);
    int          bits;
    logic [31:0] v;
    logic [31:0] mask;
    bits = 8 << f[1:0];
    v = rd >> (8 * off);
    if (bits < 32) begin
      mask = (32'h1 << bits) - 32'h1;
      v = v & mask;
      if (!f[2] && v[bits-1]) v = v | ~mask;
    end
    return v;
  endfunction

  function automatic logic [3:0] wstrb_m(bit st, logic [2:0] f, logic [1:0] off);
    int n;
    if (!st) return 4'b0000;
    n = 1 << f[1:0];
    return 4'(((1 << n) - 1) << off);
  endfunction

  function automatic logic [31:0] wdata_m(logic [2:0] f, logic [31:0] d);
    int          n;
    logic [31:0] r;
    logic [31:0] mask;
    n = 1 << f[1:0];
    if (n == 4) return d;
    mask = (32'h1 << (8 * n)) - 32'h1;
    r = 32'h0;
    for (int i = 0; i < 4 / n; i++) r = r | ((d & mask) << (8 * n * i));
    return r;
  endfunction

  // ---------------- driver ----------------
  // Starts and ends 1 time unit after a rising edge with the DUT in IDLE.
  task automatic drive_access(input bit st, input logic [2:0] f, input logic [31:0] a,
                              input logic [31:0] d, input int waits,
                              input logic [31:0] rd, output obs_t o);
    int n;
    alu_out = a; rs2_data = d; fn3 = f;
    mem_write = st; mem_read = !st; mem_ack = 1'b0;
    #1;
    o.stall_idle = stall;
    o.mis_idle   = misalign;
    o.stable     = 1'b1;
    o.stall_req  = 1'b1;
    o.addr = 32'h0; o.wdata = 32'h0; o.wstrb = 4'h0; o.we = 1'b0;
    @(posedge clk); #1;
    n = 0;
    while (mem_req === 1'b1 && n < 40) begin
      if (n == 0) begin
        o.addr = mem_addr; o.wdata = mem_wdata; o.wstrb = mem_wstrb; o.we = mem_we;
      end else if (mem_addr !== o.addr || mem_wdata !== o.wdata ||
                   mem_wstrb !== o.wstrb || mem_we !== o.we) begin
        o.stable = 1'b0;
      end
      if (stall !== 1'b1) o.stall_req = 1'b0;
      if (n == waits) begin
        mem_ack = 1'b1; mem_rdata = rd;
      end
      n++;
      @(posedge clk); #1;
      mem_ack = 1'b0; mem_rdata = $urandom;
    end
    o.req_cycles  = n;
    o.stall_end   = stall;
    o.bus_err_end = bus_err;
    o.load_end    = load_data;
    mem_read = 1'b0; mem_write = 1'b0;
    @(posedge clk); #1;
    o.req_after     = mem_req;
    o.bus_err_after = bus_err;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    alu_out = 32'h0; rs2_data = 32'h0; fn3 = 3'b000;
    mem_read = 1'b0; mem_write = 1'b0; mem_ack = 1'b0; mem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({mem_req, mem_we, mem_wstrb, bus_err, stall, misalign} !== 10'b0) begin
      bad++;
      $display("FAIL reset_ctrl: req=%b we=%b wstrb=%b err=%b stall=%b mis=%b expected all 0",
               mem_req, mem_we, mem_wstrb, bus_err, stall, misalign);
    end
    total++;
    if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || load_data !== 32'h0) begin
      bad++;
      $display("FAIL reset_data: addr=%h wdata=%h load=%h expected 0", mem_addr, mem_wdata, load_data);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_lw();
    obs_t o;
    drive_access(1'b0, 3'b010, 32'h100, 32'h0, 0, 32'hDEADBEEF, o);
    total++;
    if ({o.stall_idle, o.stall_req, o.stall_end} !== 3'b110) begin
      bad++; $display("FAIL lw_stall: got %b%b%b expected 110", o.stall_idle, o.stall_req, o.stall_end);
    end
    total++;
    if (o.req_cycles != 1) begin
      bad++; $display("FAIL lw_req_cycles: got %0d expected 1", o.req_cycles);
    end
    total++;
    if (o.load_end !== 32'hDEADBEEF) begin
      bad++; $display("FAIL lw_load: got %h expected deadbeef", o.load_end);
    end
    total++;
    if (o.addr !== 32'h100 || o.we !== 1'b0) begin
      bad++; $display("FAIL lw_addr: got addr=%h we=%b expected 00000100 0", o.addr, o.we);
    end
    total++;
    if (o.req_after !== 1'b0) begin
      bad++; $display("FAIL lw_no_reissue: mem_req=%b expected 0", o.req_after);
    end
  endtask

  task automatic test_lb();
    obs_t o;
    drive_access(1'b0, 3'b000, 32'h202, 32'h0, 1, 32'h0080_0000, o);
    total++;
    if (o.load_end !== 32'hFFFFFF80) begin
      bad++; $display("FAIL lb_sext: got %h expected ffffff80", o.load_end);
    end
    drive_access(1'b0, 3'b100, 32'h202, 32'h0, 0, 32'h0080_0000, o);
    total++;
    if (o.load_end !== 32'h00000080) begin
      bad++; $display("FAIL lbu_zext: got %h expected 00000080", o.load_end);
    end
    drive_access(1'b0, 3'b001, 32'h2, 32'h0, 0, 32'h8001_0000, o);
    total++;
    if (o.load_end !== 32'hFFFF8001) begin
      bad++; $display("FAIL lh_sext: got %h expected ffff8001", o.load_end);
    end
  endtask

  task automatic test_sh();
    obs_t o;
    drive_access(1'b1, 3'b001, 32'h306, 32'h1234ABCD, 3, 32'h0, o);
    total++;
    if (o.we !== 1'b1 || o.wstrb !== 4'b1100 || o.wdata !== 32'hABCDABCD || o.addr !== 32'h304) begin
      bad++;
      $display("FAIL sh_bus: got we=%b wstrb=%b wdata=%h addr=%h expected 1 1100 abcdabcd 00000304",
               o.we, o.wstrb, o.wdata, o.addr);
    end
    total++;
    if (o.req_cycles != 4 || o.stable !== 1'b1 || o.stall_req !== 1'b1) begin
      bad++;
      $display("FAIL sh_hold: got cycles=%0d stable=%b stall=%b expected 4 1 1",
               o.req_cycles, o.stable, o.stall_req);
    end
    total++;
    if (o.load_end !== 32'h0) begin
      bad++; $display("FAIL sh_load_zero: got %h expected 0", o.load_end);
    end
  endtask

  task automatic test_misalign();
    obs_t o;
    drive_access(1'b0, 3'b010, 32'h100, 32'h0, 0, 32'h55AA_1234, o);
    drive_access(1'b0, 3'b010, 32'h102, 32'h0, 0, 32'h0, o);
    total++;
    if (o.mis_idle !== 1'b1 || o.stall_idle !== 1'b0 || o.req_cycles != 0) begin
      bad++;
      $display("FAIL lw_misalign: got mis=%b stall=%b req_cycles=%0d expected 1 0 0",
               o.mis_idle, o.stall_idle, o.req_cycles);
    end
    total++;
    if (o.load_end !== 32'h0) begin
      bad++; $display("FAIL misalign_load: got %h expected 0", o.load_end);
    end
    drive_access(1'b0, 3'b011, 32'h100, 32'h0, 0, 32'h0, o);
    total++;
    if (o.mis_idle !== 1'b1 || o.stall_idle !== 1'b0 || o.req_cycles != 0) begin
      bad++;
      $display("FAIL fn3_011_illegal: got mis=%b stall=%b req_cycles=%0d expected 1 0 0",
               o.mis_idle, o.stall_idle, o.req_cycles);
    end
    drive_access(1'b1, 3'b100, 32'h100, 32'h0, 0, 32'h0, o);
    total++;
    if (o.mis_idle !== 1'b1 || o.req_cycles != 0) begin
      bad++; $display("FAIL sbu_illegal: got mis=%b req_cycles=%0d expected 1 0", o.mis_idle, o.req_cycles);
    end
  endtask

  task automatic test_timeout();
    obs_t o;
    drive_access(1'b0, 3'b010, 32'h40, 32'h0, 0, 32'h1357_9BDF, o);
    drive_access(1'b1, 3'b010, 32'h40, 32'hCAFE_0001, 1000, 32'h0, o);
    total++;
    if (o.req_cycles != TO) begin
      bad++; $display("FAIL timeout_req_cycles: got %0d expected %0d", o.req_cycles, TO);
    end
    total++;
    if (o.bus_err_end !== 1'b1 || o.stall_end !== 1'b0 || o.load_end !== 32'h0) begin
      bad++;
      $display("FAIL timeout_err: got err=%b stall=%b load=%h expected 1 0 0",
               o.bus_err_end, o.stall_end, o.load_end);
    end
    total++;
    if (o.bus_err_after !== 1'b0 || o.req_after !== 1'b0) begin
      bad++; $display("FAIL timeout_pulse: got err=%b req=%b expected 0 0", o.bus_err_after, o.req_after);
    end
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    total++;
    if (mem_req !== 1'b0 || load_data !== 32'h0 || stall !== 1'b0) begin
      bad++;
      $display("FAIL late_ack: got req=%b load=%h stall=%b expected 0 0 0", mem_req, load_data, stall);
    end
  endtask

  task automatic test_reset_mid_req();
    obs_t o;
    alu_out = 32'h80; rs2_data = 32'h0BAD_F00D; fn3 = 3'b010;
    mem_write = 1'b1; mem_read = 1'b0; mem_ack = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    total++;
    if (mem_req !== 1'b1) begin
      bad++; $display("FAIL mid_req_active: mem_req=%b expected 1", mem_req);
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (mem_req !== 1'b0 || mem_wstrb !== 4'b0000) begin
      bad++; $display("FAIL async_reset: got req=%b wstrb=%b expected 0 0000", mem_req, mem_wstrb);
    end
    mem_write = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    drive_access(1'b0, 3'b010, 32'h104, 32'h0, 1, 32'hCAFE_F00D, o);
    total++;
    if (o.load_end !== 32'hCAFEF00D || o.req_cycles != 2 || o.addr !== 32'h104) begin
      bad++;
      $display("FAIL post_reset_lw: got load=%h cycles=%0d addr=%h expected cafef00d 2 00000104",
               o.load_end, o.req_cycles, o.addr);
    end
  endtask

  task automatic test_random();
    obs_t        o;
    bit          st;
    logic [2:0]  f;
    logic [31:0] a, d, rd, exp_load;
    int          waits, exp_cycles;
    bit          lg;
    for (int i = 0; i < 60; i++) begin
      st    = 1'($urandom_range(0, 1));
      f     = 3'($urandom_range(0, 7));
      a     = $urandom;
      d     = $urandom;
      rd    = $urandom;
      waits = ($urandom_range(0, 9) == 0) ? 100 : $urandom_range(0, 3);
      lg    = legal_m(st, f, a);
      drive_access(st, f, a, d, waits, rd, o);
      if (!lg) begin
        total++;
        if (o.mis_idle !== 1'b1 || o.stall_idle !== 1'b0 || o.req_cycles != 0 || o.load_end !== 32'h0) begin
          bad++;
          $display("FAIL rnd_illegal[%0d]: st=%0d fn3=%b addr=%h got mis=%b stall=%b cycles=%0d load=%h expected 1 0 0 0",
                   i, st, f, a, o.mis_idle, o.stall_idle, o.req_cycles, o.load_end);
        end
        continue;
      end
      exp_cycles = (waits < TO) ? waits + 1 : TO;
      exp_load   = (!st && waits < TO) ? load_m(f, a[1:0], rd) : 32'h0;
      total++;
      if (o.stall_idle !== 1'b1 || o.mis_idle !== 1'b0 || o.req_cycles != exp_cycles || o.stable !== 1'b1) begin
        bad++;
        $display("FAIL rnd_handshake[%0d]: got stall=%b mis=%b cycles=%0d stable=%b expected 1 0 %0d 1",
                 i, o.stall_idle, o.mis_idle, o.req_cycles, o.stable, exp_cycles);
      end
      total++;
      if (o.addr !== {a[31:2], 2'b00} || o.we !== st || o.wstrb !== wstrb_m(st, f, a[1:0])) begin
        bad++;
        $display("FAIL rnd_bus[%0d]: got addr=%h we=%b wstrb=%b expected %h %b %b",
                 i, o.addr, o.we, o.wstrb, {a[31:2], 2'b00}, st, wstrb_m(st, f, a[1:0]));
      end
      if (st) begin
        total++;
        if (o.wdata !== wdata_m(f, d)) begin
          bad++; $display("FAIL rnd_wdata[%0d]: fn3=%b got %h expected %h", i, f, o.wdata, wdata_m(f, d));
        end
      end
      total++;
      if (o.load_end !== exp_load || o.bus_err_end !== (waits >= TO)) begin
        bad++;
        $display("FAIL rnd_result[%0d]: fn3=%b off=%0d got load=%h err=%b expected %h %b",
                 i, f, a[1:0], o.load_end, o.bus_err_end, exp_load, (waits >= TO));
      end
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_lb();
    test_sh();
    test_misalign();
    test_timeout();
    test_reset_mid_req();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
